mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port program memory between the CPU fetch path (cntrl_fsm mem_en
//  stage) and the program loader/debug port. One transaction in flight at a time; each
//  requester sees a req/ack handshake. Sits between cntrl_fsm/loader and the memory macro.
// PARAMETERS
//  MEM_LAT  2        cycles from mem_cs cycle to mem_rdata valid; legal range 1..7
//  ADDR_W   `CAP     memory address width (4)
//  DATA_W   `CAP*4   data frame width (16); matches data_frame
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  cpu_req    in   1       CPU fetch request; read-only requester
//  cpu_addr   in   ADDR_W  CPU fetch address
//  cpu_ack    out  1       1-cycle pulse: CPU transaction complete, cpu_data valid
//  cpu_data   out  DATA_W  registered fetched frame; holds until next CPU read completes
//  ldr_req    in   1       loader request
//  ldr_we     in   1       loader write enable (1 = write, 0 = read)
//  ldr_addr   in   ADDR_W  loader address
//  ldr_wdata  in   DATA_W  loader write data
//  ldr_ack    out  1       1-cycle pulse: loader transaction complete
//  ldr_rdata  out  DATA_W  registered read data; unchanged by loader writes
//  mem_cs     out  1       memory chip select, exactly one cycle per transaction
//  mem_we     out  1       memory write enable, valid only with mem_cs
//  mem_addr   out  ADDR_W  latched transaction address
//  mem_wdata  out  DATA_W  latched write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_cs cycle
//  busy       out  1       1 whenever state != IDLE
//  owner      out  1       current/last grant owner: 0 = CPU, 1 = loader
// BEHAVIOUR
//  Reset: state IDLE; all acks, mem_cs, mem_we, busy = 0; cpu_data, ldr_rdata, mem_addr,
//   mem_wdata = 0; owner = 1 (loader), so under round-robin the first tie goes to CPU.
//  FSM: IDLE -> GRANT -> WAIT -> DONE -> IDLE.
//   IDLE: sample cpu_req/ldr_req; if either is high, pick a winner, latch owner/addr/we/wdata
//    (CPU: we forced 0), go to GRANT. Requests are sampled only in IDLE.
//   GRANT: mem_cs = 1 for this cycle only; load counter with MEM_LAT-1; go to WAIT.
//   WAIT: lasts exactly MEM_LAT cycles; on the final cycle capture mem_rdata into the
//    owner's rdata register (reads only); go to DONE.
//   DONE: owner's ack = 1 for one cycle; go to IDLE.
//  Latency: req high in IDLE cycle c -> mem_cs at c+1 -> ack at c+2+MEM_LAT (c+4 by default).
//   Back-to-back throughput: one transaction per MEM_LAT+3 cycles.
//  Handshake: requester holds req/addr/data until ack. If req is still high in the cycle
//   after ack, that is a new request. Inputs changing after the IDLE sample have no effect.
//  Single requester always wins; the non-owner ack never pulses.
//  Reset mid-operation (any state): abort; no ack is ever issued for the aborted transaction;
//   mem_cs is low from the cycle after rst.
//  Out-of-range MEM_LAT: the implementation must raise an elaboration-time error.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: on a tie, grant the requester not equal to owner (alternating).
//  MEM_ARB_RR_EN undefined: fixed priority; on a tie the loader always wins.
// STRUCTURE
//  cpu.vh: add `MARB_S_IDLE/GRANT/WAIT/DONE (2-bit) and `MARB_OWN_CPU=0 / `MARB_OWN_LDR=1.
//  Sub-module mem_arb_sel: combinational winner pick (cpu_req, ldr_req, owner -> grant);
//   the only code affected by MEM_ARB_RR_EN.
// TESTING (mem model: rdata = {addr,~addr,addr,~addr} unless written; MEM_LAT=2)
//  1 Reset: rst high 2 cycles -> acks 0, mem_cs 0, busy 0, cpu_data = ldr_rdata = 16'h0000.
//  2 CPU read: cpu_req=1, cpu_addr=4'h3 at c -> mem_cs=1, mem_we=0, mem_addr=3 only at c+1;
//     cpu_ack at c+4 with cpu_data=16'h3C3C; ldr_ack stays 0.
//  3 Loader write then CPU read: ldr_we=1, ldr_addr=4'hA, ldr_wdata=16'h5ABF ->
//     mem_we=1, mem_wdata=16'h5ABF at c+1; ldr_ack at c+4; CPU read of 4'hA returns 16'h5ABF.
//  4 Contention: both req held high for 3 transactions -> RR_EN: owners CPU, LDR, CPU;
//     no RR_EN: LDR, LDR, LDR; one ack per transaction.
//  5 Abort: rst during WAIT -> next cycle busy 0, mem_cs 0; no ack for 10 cycles.
//  6 Stability: change cpu_addr 4'h3 -> 4'h7 during WAIT -> mem_addr stays 3,
//     cpu_data = 16'h3C3C.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the program-memory arbiter.
// Holds the FSM state encoding, the grant-owner codes and the latency-counter width.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    // Wide enough for MEM_LAT-1 across the legal range of 1..7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner pick between CPU fetch and loader; zero latency, no backpressure.
// MEM_ARB_RR_EN: ties alternate away from the last owner; otherwise the loader wins ties.
module mem_arb_sel
    import mem_arbiter_pkg::*;
(
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic owner,
    output logic grant
);

    always_comb begin
        grant = owner;
        if (cpu_req && ldr_req) begin
`ifdef MEM_ARB_RR_EN
            grant = ~owner;
`else
            grant = OWN_LDR;
`endif
        end else if (ldr_req) begin
            grant = OWN_LDR;
        end else if (cpu_req) begin
            grant = OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port program memory arbiter for CPU fetch and loader/debug port (tie policy set by MEM_ARB_RR_EN).
// Latency: request sampled in IDLE -> mem_cs next cycle -> ack MEM_LAT+2 cycles after the sample.
// Backpressure: one transaction in flight; requests are only seen in IDLE and are held until ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_check
        $error("mem_arbiter: MEM_LAT must be in 1..7");
    end

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic             grant;
    logic             any_req;

    assign any_req = cpu_req | ldr_req;

    mem_arb_sel u_sel (
        .cpu_req (cpu_req),
        .ldr_req (ldr_req),
        .owner   (owner),
        .grant   (grant)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (any_req) state_nxt = S_GRANT;
            S_GRANT: state_nxt = S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes decode straight from state so a reset drops them on the following cycle.
    assign mem_cs  = (state == S_GRANT);
    assign mem_we  = mem_cs & we_q;
    assign busy    = (state != S_IDLE);
    assign cpu_ack = (state == S_DONE) && (owner == OWN_CPU);
    assign ldr_ack = (state == S_DONE) && (owner == OWN_LDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            owner     <= OWN_LDR;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_data  <= '0;
            ldr_rdata <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner <= grant;
                        if (grant == OWN_LDR) begin
                            mem_addr  <= ldr_addr;
                            mem_wdata <= ldr_wdata;
                            we_q      <= ldr_we;
                        end else begin
                            mem_addr  <= cpu_addr;
                            mem_wdata <= '0;
                            we_q      <= 1'b0;
                        end
                    end
                end
                S_GRANT: cnt <= CNT_W'(MEM_LAT - 1);
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!we_q) begin
                        if (owner == OWN_CPU) cpu_data  <= mem_rdata;
                        else                  ldr_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a MEM_LAT=2 memory model; tie expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, ldr_req, ldr_we;
    logic [3:0]  cpu_addr, ldr_addr;
    logic [15:0] ldr_wdata;
    logic        cpu_ack, ldr_ack, mem_cs, mem_we, busy, owner;
    logic [15:0] cpu_data, ldr_rdata, mem_wdata;
    logic [3:0]  mem_addr;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [16];
    logic [15:0] rd_pipe;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(2), .ADDR_W(4), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ack   (cpu_ack),
        .cpu_data  (cpu_data),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_ack   (ldr_ack),
        .ldr_rdata (ldr_rdata),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    // Two-stage read pipe: data valid two cycles after the mem_cs cycle, junk otherwise.
    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe   <= mem_cs ? mem[mem_addr] : 16'hDEAD;
        mem_rdata <= rd_pipe;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
    endtask

    logic       got;
    logic [2:0] exp_own;
    int         acks;

    initial begin
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a;
            a = 4'(i);
            mem[i] = {a, ~a, a, ~a};
        end
        rd_pipe = 16'hDEAD;
        mem_rdata = 16'hDEAD;
        cpu_req = 0; ldr_req = 0; ldr_we = 0;
        cpu_addr = 0; ldr_addr = 0; ldr_wdata = 0;
`ifdef MEM_ARB_RR_EN
        exp_own = 3'b010;
`else
        exp_own = 3'b111;
`endif

        // 1: reset state
        do_reset(2);
        chk("rst_cpu_ack", {15'd0, cpu_ack}, 16'd0);
        chk("rst_ldr_ack", {15'd0, ldr_ack}, 16'd0);
        chk("rst_mem_cs", {15'd0, mem_cs}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_owner", {15'd0, owner}, 16'd1);
        chk("rst_cpu_data", cpu_data, 16'h0000);
        chk("rst_ldr_rdata", ldr_rdata, 16'h0000);

        // 2: CPU read of address 3
        cpu_req = 1; cpu_addr = 4'h3;
        step();
        chk("rd_cs", {15'd0, mem_cs}, 16'd1);
        chk("rd_we", {15'd0, mem_we}, 16'd0);
        chk("rd_addr", {12'd0, mem_addr}, 16'h3);
        step();
        chk("rd_cs_once", {15'd0, mem_cs}, 16'd0);
        chk("rd_no_early_ack", {15'd0, cpu_ack}, 16'd0);
        step();
        step();
        chk("rd_cpu_ack", {15'd0, cpu_ack}, 16'd1);
        chk("rd_ldr_ack", {15'd0, ldr_ack}, 16'd0);
        chk("rd_cpu_data", cpu_data, 16'h3C3C);
        cpu_req = 0;
        step();
        chk("rd_ack_pulse", {15'd0, cpu_ack}, 16'd0);
        chk("rd_idle", {15'd0, busy}, 16'd0);

        // 3: loader write of 5ABF to A, then CPU read and loader read of A
        ldr_req = 1; ldr_we = 1; ldr_addr = 4'hA; ldr_wdata = 16'h5ABF;
        step();
        chk("wr_cs", {15'd0, mem_cs}, 16'd1);
        chk("wr_we", {15'd0, mem_we}, 16'd1);
        chk("wr_wdata", mem_wdata, 16'h5ABF);
        step(); step(); step();
        chk("wr_ldr_ack", {15'd0, ldr_ack}, 16'd1);
        chk("wr_cpu_ack", {15'd0, cpu_ack}, 16'd0);
        chk("wr_rdata_keep", ldr_rdata, 16'h0000);
        ldr_req = 0; ldr_we = 0;
        cpu_req = 1; cpu_addr = 4'hA;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (cpu_ack) got = 1;
        end
        chk("rdA_ack_seen", {15'd0, got}, 16'd1);
        chk("rdA_cpu_data", cpu_data, 16'h5ABF);
        cpu_req = 0;
        ldr_req = 1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (ldr_ack) got = 1;
        end
        chk("ldrA_ack_seen", {15'd0, got}, 16'd1);
        chk("ldrA_rdata", ldr_rdata, 16'h5ABF);
        ldr_req = 0;
        step();

        // 4: contention over three back-to-back transactions from reset
        do_reset(1);
        cpu_req = 1; cpu_addr = 4'h1;
        ldr_req = 1; ldr_addr = 4'h2; ldr_we = 0;
        for (int t = 0; t < 3; t++) begin
            got = 0;
            for (int k = 0; k < 12 && !got; k++) begin
                step();
                if (cpu_ack || ldr_ack) got = 1;
            end
            acks = int'(cpu_ack) + int'(ldr_ack);
            chk($sformatf("tie%0d_ack_seen", t), {15'd0, got}, 16'd1);
            chk($sformatf("tie%0d_owner", t), {15'd0, owner}, {15'd0, exp_own[t]});
            chk($sformatf("tie%0d_ldr_ack", t), {15'd0, ldr_ack}, {15'd0, exp_own[t]});
            chk($sformatf("tie%0d_one_ack", t), 16'(acks), 16'd1);
        end
        cpu_req = 0; ldr_req = 0;
        step();

        // 5: reset during WAIT aborts without an ack
        do_reset(1);
        cpu_req = 1; cpu_addr = 4'h5;
        step(); step();
        chk("abt_in_wait", {15'd0, busy}, 16'd1);
        rst = 1; cpu_req = 0;
        step();
        rst = 0;
        chk("abt_busy", {15'd0, busy}, 16'd0);
        chk("abt_cs", {15'd0, mem_cs}, 16'd0);
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            acks += int'(cpu_ack) + int'(ldr_ack) + int'(mem_cs);
        end
        chk("abt_no_ack", 16'(acks), 16'd0);

        // 6: address change after the IDLE sample is ignored
        cpu_req = 1; cpu_addr = 4'h3;
        step(); step();
        cpu_addr = 4'h7;
        step();
        chk("stab_addr", {12'd0, mem_addr}, 16'h3);
        step();
        chk("stab_ack", {15'd0, cpu_ack}, 16'd1);
        chk("stab_data", cpu_data, 16'h3C3C);
        cpu_req = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
